// File: rtl/p_accum_stage.sv
// p_accum_stage: P-register / accumulation control stage behind a post-adder.
// It registers the post-adder result into p_out. It also sequences
// multi-sample accumulations:
//   IDLE -> ACC -> DONE
// fb_sel asks the upstream adder to fold p_out back in.
// Optional feature: define P_ACCUM_SAT_EN to saturate on carry/borrow out
// instead of wrapping.
module p_accum_stage #(
    parameter int unsigned WIDTH       = 18,
    parameter int unsigned CARRYOUTREG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             in_valid,
    input  logic             acc_start,
    input  logic [7:0]       acc_len,
    input  logic             sub,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    output logic [WIDTH-1:0] p_out,
    output logic             carryout,
    output logic             fb_sel,
    output logic             out_valid,
    output logic             acc_done,
    output logic [7:0]       acc_cnt,
    output logic             sat_flag
);

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       cnt_inc;
    logic [7:0]       eff_len;
    logic [WIDTH-1:0] p_q, p_d;
    logic             sat_q, sat_d;
    logic             valid_q;
    logic             accept;

    assign accept  = ce & in_valid;
    // A length of zero behaves like a single-sample accumulation.
    assign eff_len = (acc_len == 8'd0) ? 8'd1 : acc_len;
    // The sample counter sticks at 255 rather than wrapping.
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

`ifdef P_ACCUM_SAT_EN
    // Clamp toward the overflow direction when the adder carried/borrowed out.
    always_comb begin
        p_d   = sum_in;
        sat_d = 1'b0;
        if (cout_in) begin
            p_d   = sub ? '0 : '1;
            sat_d = 1'b1;
        end
    end
`else
    logic unused_sub;
    assign unused_sub = sub;

    // Wrap-around mode: the adder result passes through unmodified.
    always_comb begin
        p_d   = sum_in;
        sat_d = 1'b0;
    end
`endif

    // Next-state and counter logic; everything holds while ce is low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ce) begin
            if (accept) begin
                if (acc_start) begin
                    // A start always loads, and aborts any run in progress.
                    cnt_d   = 8'd1;
                    state_d = (eff_len == 8'd1) ? StDone : StAcc;
                end else if (state_q == StAcc) begin
                    cnt_d   = cnt_inc;
                    // The >= comparison lets a shrunken acc_len end the run.
                    state_d = (cnt_inc >= eff_len) ? StDone : StAcc;
                end else begin
                    state_d = StIdle;
                end
            end else if (state_q == StDone) begin
                state_d = StIdle;
            end
        end
    end

    // FSM, counter and valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= accept;
        end
    end

    // P register and saturation flag update only on accepted samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            sat_q <= 1'b0;
        end else if (accept) begin
            p_q   <= p_d;
            sat_q <= sat_d;
        end
    end

    if (CARRYOUTREG != 0) begin : g_co_reg
        logic co_q;

        // The carry is registered alongside p_out so the two stay aligned.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                co_q <= 1'b0;
            end else if (accept) begin
                co_q <= cout_in;
            end
        end

        assign carryout = co_q;
    end else begin : g_co_comb
        assign carryout = cout_in;
    end

    assign p_out     = p_q;
    assign out_valid = valid_q;
    assign acc_cnt   = cnt_q;
    assign sat_flag  = sat_q;
    assign fb_sel    = (state_q == StAcc);
    assign acc_done  = (state_q == StDone);

endmodule

// File: tb/tb_p_accum_stage.sv
// Bench for p_accum_stage: directed scenarios pinned by literal values, then
// randomized traffic checked every cycle against an accumulation-level model.
module tb_p_accum_stage;

    localparam int unsigned W = 18;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ce;
    logic         in_valid;
    logic         acc_start;
    logic [7:0]   acc_len;
    logic         sub;
    logic [W-1:0] sum_in;
    logic         cout_in;
    logic [W-1:0] p_out;
    logic         carryout;
    logic         fb_sel;
    logic         out_valid;
    logic         acc_done;
    logic [7:0]   acc_cnt;
    logic         sat_flag;

    always #5 clk = ~clk;

    p_accum_stage #(
        .WIDTH       (W),
        .CARRYOUTREG (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .in_valid  (in_valid),
        .acc_start (acc_start),
        .acc_len   (acc_len),
        .sub       (sub),
        .sum_in    (sum_in),
        .cout_in   (cout_in),
        .p_out     (p_out),
        .carryout  (carryout),
        .fb_sel    (fb_sel),
        .out_valid (out_valid),
        .acc_done  (acc_done),
        .acc_cnt   (acc_cnt),
        .sat_flag  (sat_flag)
    );

    // Model: "running" means an accumulation is open, "finished" means the
    // last result of one is on p_out.
    int unsigned  checks   = 0;
    int unsigned  failures = 0;
    logic [W-1:0] m_p;
    logic         m_co;
    logic         m_sat;
    logic         m_ov;
    int unsigned  m_cnt;
    bit           m_running;
    bit           m_finished;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_p = '0; m_co = 1'b0; m_sat = 1'b0; m_ov = 1'b0;
        m_cnt = 0; m_running = 1'b0; m_finished = 1'b0;
    endtask

    // Effect of one rising edge given the inputs currently applied.
    task automatic model_edge();
        int unsigned len;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!ce) begin
            m_ov = 1'b0;
            return;
        end
        m_ov = in_valid;
        len  = (acc_len == 0) ? 1 : int'(acc_len);
        if (!in_valid) begin
            m_finished = 1'b0;
            return;
        end
        m_co = cout_in;
`ifdef P_ACCUM_SAT_EN
        m_sat = cout_in;
        m_p   = cout_in ? (sub ? {W{1'b0}} : {W{1'b1}}) : sum_in;
`else
        m_sat = 1'b0;
        m_p   = sum_in;
`endif
        if (acc_start) begin
            m_cnt      = 1;
            m_finished = (len == 1);
            m_running  = !m_finished;
        end else if (m_running) begin
            m_cnt      = (m_cnt == 255) ? 255 : m_cnt + 1;
            m_finished = (m_cnt >= len);
            m_running  = !m_finished;
        end else begin
            m_finished = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("p_out", 32'(p_out), 32'(m_p));
        chk("carryout", 32'(carryout), 32'(m_co));
        chk("fb_sel", 32'(fb_sel), 32'(m_running));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("acc_done", 32'(acc_done), 32'(m_finished));
        chk("acc_cnt", 32'(acc_cnt), m_cnt);
        chk("sat_flag", 32'(sat_flag), 32'(m_sat));
    endtask

    // One clock: the model follows the edge, outputs are compared 1ns later.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic c, input logic v, input logic st, input logic [7:0] len,
                         input logic s, input logic [W-1:0] d, input logic co);
        ce = c; in_valid = v; acc_start = st; acc_len = len; sub = s; sum_in = d; cout_in = co;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 18'h00555, 1'b1);
        cyc();
        cyc();
        chk("reset_p_out", 32'(p_out), 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        #2 rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'd3, 1'b0, '0, 1'b0);
        cyc();

        // Accumulation of three samples.
        drive(1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 18'd5, 1'b0);
        cyc();
        chk("acc3_p0", 32'(p_out), 32'd5);
        chk("acc3_fb0", 32'(fb_sel), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 18'd12, 1'b0);
        cyc();
        chk("acc3_p1", 32'(p_out), 32'd12);
        drive(1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 18'd30, 1'b0);
        cyc();
        chk("acc3_p2", 32'(p_out), 32'd30);
        chk("acc3_done", 32'(acc_done), 32'd1);
        chk("acc3_cnt", 32'(acc_cnt), 32'd3);
        drive(1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 18'd0, 1'b0);
        cyc();
        chk("acc3_done_exit", 32'(acc_done), 32'd0);
        chk("idle_no_valid", 32'(out_valid), 32'd0);

        // Clock-enable freeze in the middle of a run.
        drive(1'b1, 1'b1, 1'b1, 8'd4, 1'b0, 18'd1, 1'b0);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 8'd4, 1'b0, 18'h3FFFF, 1'b1);
        cyc();
        cyc();
        chk("ce0_p_out", 32'(p_out), 32'd1);
        chk("ce0_cnt", 32'(acc_cnt), 32'd1);
        chk("ce0_fb", 32'(fb_sel), 32'd1);
        chk("ce0_valid", 32'(out_valid), 32'd0);

        // Restart while accumulating.
        drive(1'b1, 1'b1, 1'b1, 8'd4, 1'b0, 18'd7, 1'b0);
        cyc();
        chk("restart_p", 32'(p_out), 32'd7);
        chk("restart_cnt", 32'(acc_cnt), 32'd1);
        chk("restart_fb", 32'(fb_sel), 32'd1);
        chk("restart_done", 32'(acc_done), 32'd0);

        // Asynchronous reset mid-accumulation.
        drive(1'b1, 1'b1, 1'b0, 8'd4, 1'b0, 18'h00123, 1'b0);
        cyc();
        chk("pre_rst_p", 32'(p_out), 32'h123);
        chk("pre_rst_cnt", 32'(acc_cnt), 32'd2);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_p", 32'(p_out), 32'h0);
        chk("arst_cnt", 32'(acc_cnt), 32'd0);
        chk("arst_fb", 32'(fb_sel), 32'd0);
        chk("arst_done", 32'(acc_done), 32'd0);
        cyc();
        chk("rst_no_accept", 32'(out_valid), 32'd0);
        rst_n = 1'b1;

        // Carry-out handling: saturation or wrap depending on the build.
        drive(1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 18'h00010, 1'b1);
        cyc();
        chk("co_carryout", 32'(carryout), 32'd1);
`ifdef P_ACCUM_SAT_EN
        chk("sat_add_p", 32'(p_out), 32'h3FFFF);
        chk("sat_add_flag", 32'(sat_flag), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 18'h00010, 1'b1);
        cyc();
        chk("sat_sub_p", 32'(p_out), 32'h0);
`else
        chk("wrap_p", 32'(p_out), 32'h10);
        chk("wrap_flag", 32'(sat_flag), 32'd0);
`endif

        // Zero length acts as one.
        drive(1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 18'd9, 1'b0);
        cyc();
        chk("len0_done", 32'(acc_done), 32'd1);
        chk("len0_cnt", 32'(acc_cnt), 32'd1);

        // Longest run reaches the counter ceiling.
        drive(1'b1, 1'b1, 1'b1, 8'd255, 1'b0, 18'd1, 1'b0);
        cyc();
        for (int i = 0; i < 254; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'd255, 1'b0, 18'(i), 1'b0);
            cyc();
        end
        chk("len255_cnt", 32'(acc_cnt), 32'd255);
        chk("len255_done", 32'(acc_done), 32'd1);

        // Randomized traffic, including mid-run length changes and resets.
        acc_len = 8'd3;
        for (int i = 0; i < 4000; i++) begin
            ce        = ($urandom_range(0, 99) < 85);
            in_valid  = ($urandom_range(0, 99) < 70);
            acc_start = ($urandom_range(0, 99) < 15);
            sub       = 1'($urandom);
            cout_in   = ($urandom_range(0, 99) < 25);
            sum_in    = W'($urandom);
            if ($urandom_range(0, 99) < 10) begin
                acc_len = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1;
                compare_all();
                cyc();
                rst_n = 1'b1;
            end else begin
                cyc();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
